// File: rtl/fetch_pkg.sv
// fetch_pkg: fetch FSM states, queue entry layout {pc, instr} and INSTR_W shared by fetch_unit and its bench
package fetch_pkg;
  localparam int INSTR_W = 32;
  localparam int PC_W = 64;
  typedef enum logic [1:0] {RUN, WAIT, DRAIN, HALT} state_t;
  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: flushable instruction queue; ports clk/reset_n, push/din, pop/dout(head), flush, count
module fetch_fifo #(
  parameter int W = 96,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] rd, wr;
  logic do_push, do_pop;
  assign do_pop = pop && count != '0;
  assign do_push = push && (count != CW'(DEPTH) || do_pop);
  assign dout = mem[rd];
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      if (do_push) mem[wr] <= din;
      if (do_push) wr <= wr + AW'(1);
      if (do_pop) rd <= rd + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetcher; ports clk/reset_n, imem_req/addr/gnt/rvalid/rdata, redirect_valid/pc, out_valid/ready/pc/instr, misalign
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int             XLEN = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int             QDEPTH = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  output logic               imem_req,
  output logic [XLEN-1:0]    imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic               misalign
);
  localparam int CW = $clog2(QDEPTH) + 1;
  state_t state, state_n;
  logic [XLEN-1:0] pc, pc_n, addr_q;
  logic pend, pend_n, misalign_n, req_n, gnt_fire, push, pop;
  logic [CW-1:0] count, count_n;
  entry_t din, head;
  assign gnt_fire = imem_req && imem_gnt;
  assign push = imem_rvalid && pend && state == WAIT && !redirect_valid;
  assign pop = out_valid && out_ready;
  assign out_valid = count != '0;
  assign imem_addr = pc;
  assign din = '{pc: PC_W'(addr_q), instr: imem_rdata};
  assign out_pc = XLEN'(head.pc);
  assign out_instr = head.instr;
  always_comb begin
    pend_n = gnt_fire || (pend && !imem_rvalid);
    misalign_n = redirect_valid ? redirect_pc[1:0] != 2'b00 : misalign;
    pc_n = redirect_valid ? redirect_pc : gnt_fire ? pc + XLEN'(4) : pc;
    count_n = redirect_valid ? '0 : count + CW'(push) - CW'(pop);
    state_n = misalign_n ? HALT : !pend_n ? RUN : (redirect_valid || state == DRAIN) ? DRAIN : WAIT;
    req_n = state_n == RUN && count_n < CW'(QDEPTH);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= RUN;
      pc <= RESET_PC;
      addr_q <= '0;
      pend <= 1'b0;
      misalign <= 1'b0;
      imem_req <= 1'b0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      pend <= pend_n;
      misalign <= misalign_n;
      imem_req <= req_n;
      if (gnt_fire) addr_q <= pc;
    end
  fetch_fifo #(.W($bits(entry_t)), .DEPTH(QDEPTH)) u_fifo (
    .clk(clk),
    .reset_n(reset_n),
    .push(push),
    .pop(pop),
    .flush(redirect_valid),
    .din(din),
    .dout(head),
    .count(count)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized fetch stream checked against a queue-level model, plus directed redirect/halt/reset/wrap cases
module tb_fetch_unit;
  localparam int QD = 4;
  typedef struct { logic [63:0] addr; bit stale; } pend_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n, imem_req, imem_gnt, imem_rvalid, redirect_valid, out_valid, out_ready, misalign;
  logic [63:0] imem_addr, redirect_pc, out_pc;
  logic [31:0] imem_rdata, out_instr;
  logic w_rst_n, w_req, w_gnt, w_rvalid, w_valid, w_mis;
  logic [31:0] w_addr, w_rdata, w_pc, w_instr;
  fetch_unit u_dut (
    .clk(clk), .reset_n(reset_n), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_instr(out_instr), .misalign(misalign)
  );
  fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .reset_n(w_rst_n), .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(w_gnt),
    .imem_rvalid(w_rvalid), .imem_rdata(w_rdata), .redirect_valid(1'b0), .redirect_pc(32'h0),
    .out_valid(w_valid), .out_ready(1'b1), .out_pc(w_pc), .out_instr(w_instr), .misalign(w_mis)
  );
  int tests = 0, fails = 0, mcount = 0, pops = 0, grants = 0;
  bit mmis, hold, retgt;
  logic [63:0] exp_fetch, exp_pop, hold_addr, retgt_addr;
  pend_t pq[$];
  function automatic logic [31:0] word(input logic [63:0] a);
    return a[31:0] * 32'h9E37_79B1 ^ a[63:32] ^ 32'h5A5A_0F0F;
  endfunction
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic cycle(input bit g, input bit rdy, input bit rv, input bit rd, input logic [63:0] tgt);
    @(negedge clk);
    check("out_valid", 64'(out_valid), 64'(mcount != 0));
    check("misalign", 64'(misalign), 64'(mmis));
    if (imem_req) check("req_rule", 64'(pq.size() == 0 && !mmis && mcount < QD), 64'd1);
    if (hold) begin
      check("req_hold", 64'(imem_req), 64'd1);
      check("addr_hold", imem_addr, hold_addr);
    end
    if (retgt) begin
      check("retarget_req", 64'(imem_req), 64'd1);
      check("retarget_addr", imem_addr, retgt_addr);
    end
    out_ready = rdy;
    imem_gnt = g;
    redirect_valid = rd;
    redirect_pc = tgt;
    imem_rvalid = rv;
    imem_rdata = $urandom;
    if (mcount != 0 && rdy) begin
      check("out_pc", out_pc, exp_pop);
      check("out_instr", 64'(out_instr), 64'(word(exp_pop)));
      exp_pop += 64'd4;
      mcount--;
      pops++;
    end
    if (rv && pq.size() != 0) begin
      imem_rdata = word(pq[0].addr);
      if (!pq[0].stale && !rd) mcount++;
      void'(pq.pop_front());
    end
    if (imem_req && g) begin
      check("fetch_addr", imem_addr, exp_fetch);
      pq.push_back('{imem_addr, 1'b0});
      exp_fetch += 64'd4;
      grants++;
    end
    if (rd) begin
      mcount = 0;
      mmis = tgt[1:0] != 2'b00;
      exp_fetch = tgt;
      exp_pop = tgt;
      foreach (pq[i]) pq[i].stale = 1'b1;
    end
    check("q_bound", 64'(mcount <= QD), 64'd1);
    hold = imem_req && !g && !rd;
    hold_addr = imem_addr;
    retgt = rd && !mmis && pq.size() == 0;
    retgt_addr = tgt;
  endtask
  task automatic do_reset();
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    imem_gnt = 1'b0;
    imem_rvalid = 1'b0;
    redirect_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    check("rst_req", 64'(imem_req), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_mis", 64'(misalign), 64'd0);
    check("rst_out_pc", out_pc, 64'd0);
    check("rst_out_instr", 64'(out_instr), 64'd0);
    check("rst_addr", imem_addr, 64'd0);
    pq.delete();
    mcount = 0;
    mmis = 1'b0;
    exp_fetch = '0;
    exp_pop = '0;
    hold = 1'b0;
    retgt = 1'b0;
    grants = 0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask
  initial begin
    int p0;
    logic [63:0] t;
    logic [31:0] wa;
    bit wp;
    logic [31:0] wpops[$];
    reset_n = 1'b0;
    imem_rdata = '0;
    redirect_pc = '0;
    w_rst_n = 1'b0;
    w_gnt = 1'b1;
    w_rvalid = 1'b0;
    w_rdata = '0;
    do_reset();
    cycle(0, 1, 0, 0, 0);
    check("first_req", 64'(imem_req), 64'd1);
    check("first_addr", imem_addr, 64'd0);
    p0 = pops;
    repeat (12) cycle(1, 1, 1, 0, 0);
    check("stream_pops", 64'(pops - p0 >= 3), 64'd1);
    do_reset();
    repeat (20) cycle(1, 0, 1, 0, 0);
    check("full_grants", 64'(grants), 64'd4);
    check("full_noreq", 64'(imem_req), 64'd0);
    check("full_head", out_pc, 64'd0);
    repeat (10) cycle(1, 1, 1, 0, 0);
    check("resume", 64'(grants > 4), 64'd1);
    for (int i = 0; i < 10 && pq.size() == 0; i++) cycle(1, 1, 0, 0, 0);
    check("wait_reached", 64'(pq.size() != 0), 64'd1);
    cycle(0, 1, 0, 1, 64'h100);
    cycle(0, 1, 1, 0, 0);
    p0 = pops;
    repeat (10) cycle(1, 1, 1, 0, 0);
    check("redir_pops", 64'(pops - p0 >= 2), 64'd1);
    cycle(0, 1, 0, 1, 64'h102);
    repeat (5) cycle(1, 1, 1, 0, 0);
    check("halt_mis", 64'(misalign), 64'd1);
    check("halt_noreq", 64'(imem_req), 64'd0);
    cycle(0, 1, 0, 1, 64'h200);
    p0 = pops;
    repeat (10) cycle(1, 1, 1, 0, 0);
    check("unhalt_mis", 64'(misalign), 64'd0);
    check("unhalt_pops", 64'(pops - p0 >= 2), 64'd1);
    for (int i = 0; i < 10 && pq.size() == 0; i++) cycle(1, 1, 0, 0, 0);
    do_reset();
    cycle(0, 1, 1, 0, 0);
    cycle(0, 1, 0, 0, 0);
    check("post_rst_valid", 64'(out_valid), 64'd0);
    check("post_rst_addr", imem_addr, 64'd0);
    repeat (8) cycle(1, 1, 1, 0, 0);
    p0 = pops;
    for (int i = 0; i < 2500; i++) begin
      t = ($urandom % 4 == 0) ? 64'hFFFF_FFFF_FFFF_FFF0 : {32'd0, $urandom} & ~64'h3;
      if ($urandom % 8 == 0) t[1:0] = 2'($urandom_range(1, 3));
      cycle($urandom % 3 != 0, ((i / 200) % 2 == 1) ? ($urandom % 4 != 0) : ($urandom % 4 == 0),
            $urandom % 2 == 1, $urandom % 24 == 0, t);
    end
    check("progress", 64'(pops - p0 > 100), 64'd1);
    @(negedge clk);
    w_rst_n = 1'b1;
    wp = 1'b0;
    wa = '0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (w_valid) begin
        wpops.push_back(w_pc);
        check("w_instr", 64'(w_instr), 64'(word(64'(w_pc))));
      end
      w_rvalid = wp;
      w_rdata = word(64'(wa));
      wp = w_req;
      wa = w_addr;
    end
    check("w_pops", 64'(wpops.size() >= 3), 64'd1);
    if (wpops.size() >= 3) begin
      check("w_pc0", 64'(wpops[0]), 64'hFFFF_FFFC);
      check("w_pc1", 64'(wpops[1]), 64'h0);
      check("w_pc2", 64'(wpops[2]), 64'h4);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
